// File: rtl/adc_autorange.sv
// Automatic x1/x10 gain ranging for one ADC channel: windowed peak detection,
// immediate drop to x1 on near-clipping samples, and blanking after each change.
module adc_autorange #(
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned WINDOW        = 1024,
  parameter logic [15:0] LOW_THRESH    = 16'd2800,
  parameter logic [15:0] HIGH_THRESH   = 16'd31000,
  parameter logic [15:0] SETTLE_CYCLES = 16'd2000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       auto_en,
  input  logic                       manual_x10,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic [1:0]                 gain_out,
  output logic                       settling,
  output logic                       range_change,
  output logic [SAMPLE_W-2:0]        peak_out,
  output logic                       peak_valid,
  output logic [1:0]                 fsm_state
);

  localparam int unsigned MW          = SAMPLE_W - 1;
  localparam logic [15:0] SETTLE_LOAD = SETTLE_CYCLES - 16'd1;
  localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                state;
  logic [15:0]           settle_cnt;
  logic [15:0]           win_cnt;
  logic [MW-1:0]         peak_reg;
  logic                  gain_x10;

  logic [SAMPLE_W-1:0]   neg_sample;
  logic [MW-1:0]         mag;
  logic [MW-1:0]         win_max;
  logic                  is_clip;
  logic                  is_low;

  // Saturating magnitude: the most negative code maps to the largest positive one.
  always_comb begin
    neg_sample = -sample_in;
    mag        = sample_in[MW-1:0];
    if (sample_in[SAMPLE_W-1]) begin
      if (sample_in[MW-1:0] == '0) mag = '1;
      else                         mag = neg_sample[MW-1:0];
    end
    win_max = (mag > peak_reg) ? mag : peak_reg;
    is_clip = gain_x10 && (32'(mag) >= 32'(HIGH_THRESH));
    is_low  = 32'(win_max) < 32'(LOW_THRESH);
  end

  assign gain_out  = {1'b0, gain_x10};
  assign fsm_state = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_SETTLE;
      settle_cnt   <= SETTLE_LOAD;
      gain_x10     <= 1'b0;
      win_cnt      <= '0;
      peak_reg     <= '0;
      peak_out     <= '0;
      peak_valid   <= 1'b0;
      range_change <= 1'b0;
      settling     <= 1'b1;
    end else begin
      peak_valid   <= 1'b0;
      range_change <= 1'b0;
      // Manual mode overrides any decision made in the same cycle.
      if (!auto_en) begin
        state    <= ST_MANUAL;
        gain_x10 <= manual_x10;
        win_cnt  <= '0;
        peak_reg <= '0;
        settling <= 1'b0;
      end else begin
        case (state)
          ST_MANUAL: begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            settling   <= 1'b1;
          end
          ST_SETTLE: begin
            if (settle_cnt == 16'd0) begin
              state    <= ST_TRACK;
              settling <= 1'b0;
              win_cnt  <= '0;
              peak_reg <= '0;
            end else begin
              settle_cnt <= settle_cnt - 16'd1;
            end
          end
          ST_TRACK: begin
            if (sample_valid) begin
              if (is_clip) begin
                gain_x10     <= 1'b0;
                range_change <= 1'b1;
                state        <= ST_SETTLE;
                settle_cnt   <= SETTLE_LOAD;
                settling     <= 1'b1;
                win_cnt      <= '0;
                peak_reg     <= '0;
              end else if (win_cnt == WIN_LAST) begin
                peak_out   <= win_max;
                peak_valid <= 1'b1;
                win_cnt    <= '0;
                peak_reg   <= '0;
                if (!gain_x10 && is_low) begin
                  gain_x10     <= 1'b1;
                  range_change <= 1'b1;
                  state        <= ST_SETTLE;
                  settle_cnt   <= SETTLE_LOAD;
                  settling     <= 1'b1;
                end
              end else begin
                peak_reg <= win_max;
                win_cnt  <= win_cnt + 16'd1;
              end
            end
          end
          default: begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            settling   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/adc_autorange.md
# adc_autorange

Per-channel automatic gain-ranging controller that sits directly upstream of the ADC analog front-end controller and drives its 2-bit gain request input (`gain0_in` or `gain1_in`). It measures the peak magnitude of incoming ADC samples over fixed windows. It requests x10 gain when the signal stays small and drops back to x1 immediately on near-clipping samples. After every gain change it blanks the measurement for a settling interval.

## Interface

Parameters:
- SAMPLE_W, 16: ADC sample width, two's complement.
- WINDOW, 1024: samples per measurement window, 2 to 65535.
- LOW_THRESH, 16'd2800: in x1, a window peak strictly below this requests x10.
- HIGH_THRESH, 16'd31000: in x10, any |sample| >= this forces x1.
- SETTLE_CYCLES, 16'd2000: clk_in cycles of blanking after a gain change, minimum 1.

Ports (reset rst_in, asynchronous, active-high; clock clk_in):
- clk_in  input  1  system clock (same as the AFE controller).
- rst_in  input  1  asynchronous active-high reset.
- auto_en  input  1  1 = automatic ranging, 0 = manual.
- manual_x10  input  1  gain used in manual mode.
- sample_in  input  SAMPLE_W  signed ADC sample.
- sample_valid  input  1  sample_in qualifier, one cycle per sample.
- gain_out  output  2  {1'b0, x10}; connects to the AFE gain input.
- settling  output  1  high while in SETTLE.
- range_change  output  1  one-cycle pulse on every automatic gain change.
- peak_out  output  SAMPLE_W-1  peak magnitude of the last completed window.
- peak_valid  output  1  one-cycle pulse when peak_out updates.

## Operation

- Magnitude: abs = |sample_in|, SAMPLE_W-1 bits, saturating; -2^(W-1) maps to 2^(W-1)-1.
- States: MANUAL, TRACK, SETTLE.
- Reset: state SETTLE, settle counter = SETTLE_CYCLES-1, gain x1, win_cnt = 0, peak_reg = 0, peak_out = 0, all pulses 0, settling = 1.
- auto_en = 0 from any state: go to MANUAL next edge. gain_out = {0, manual_x10} every cycle. Samples ignored, win_cnt and peak_reg held at 0, settling = 0.
- MANUAL with auto_en = 1: go to SETTLE, keep current gain, load settle counter.
- SETTLE: counter decrements each clk_in and samples are ignored. When the counter reaches 0, go to TRACK with win_cnt = 0 and peak_reg = 0.
- TRACK, on each sample_valid, in priority order:
  1. Gain is x10 and abs >= HIGH_THRESH: set x1, pulse range_change, go to SETTLE, discard the window (no peak_valid).
  2. win_cnt == WINDOW-1: peak_out = max(peak_reg, abs), pulse peak_valid. If gain is x1 and that max < LOW_THRESH, set x10, pulse range_change, go to SETTLE. Otherwise clear win_cnt and peak_reg and stay in TRACK.
  3. Otherwise: peak_reg = max(peak_reg, abs), win_cnt + 1.
- In x10 there is no upward step. In x1, HIGH_THRESH is ignored.
- No other condition changes gain.

## Timing

- Every output is registered.
- gain_out, range_change and peak_valid update on the first clk_in edge after the sample_valid cycle (latency 1).
- settling rises on that same edge. It stays high for exactly SETTLE_CYCLES cycles and falls on the edge that enters TRACK. The first sample counted is in the cycle after that edge.
- SETTLE_CYCLES must exceed the AFE update time: CLK_DIV × 3 slow ticks, about 75 cycles at the default divider.
- Simultaneous events:
  - Clip and window end on the same sample: the clip wins and no peak_valid is issued.
  - auto_en falling in the same cycle as a switch decision: MANUAL wins, there is no range_change, and gain follows manual_x10.
- Reset mid-window or mid-settle returns all state to the reset values.

## Test plan

- Reset: assert rst_in mid-operation. Expect gain_out = 00, settling = 1, peak_out = 0, no pulses. After SETTLE_CYCLES cycles, settling falls.
- Upward step (WINDOW = 8, SETTLE_CYCLES = 10), auto_en = 1, x1:
  - Feed 8 samples of ±2799. Expect peak_out = 2799, peak_valid and range_change pulses, gain_out = 01 one cycle after the 8th sample, settling high for 10 cycles.
  - Repeat with one sample at exactly 2800. Expect peak_valid only and gain stays 00.
- Clip in x10: feed 3 small samples, then -31000. Expect gain_out = 00 one cycle later, range_change pulse, no peak_valid. A following window restarts at win_cnt = 0.
- Saturation: in x1, send -32768 as the 8th sample. Expect peak_out = 32767 and no step.
- Settle blanking: during SETTLE, send 20 samples of 32767. Expect no gain change. The subsequent window counts only samples after settling falls.
- Manual override: deassert auto_en while in x10 SETTLE with manual_x10 = 0. Expect gain_out = 00 next cycle, settling = 0, no range_change. Toggling manual_x10 tracks with 1-cycle latency. Reasserting auto_en gives settling = 1 for SETTLE_CYCLES.
